// File: rtl/axi_wr_addr_burst_expander_if.sv
// AW-channel and per-beat token bundle shared by the burst expander and its master.
interface axi_wr_addr_burst_expander_if #(
  parameter int ID_W       = 4,
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [LEN_W-1:0]  awlen;
  logic              awvalid;
  logic              awready;
  logic              beat_valid;
  logic              beat_ready;
  logic [ADDR_W-1:0] beat_addr;
  logic [ID_W-1:0]   beat_id;
  logic [LEN_W-1:0]  beat_idx;
  logic              beat_last;
  logic [CNT_W-1:0]  fifo_count;
  logic [15:0]       bursts_done;

  modport slave (
    input  awid, awaddr, awlen, awvalid, beat_ready,
    output awready, beat_valid, beat_addr, beat_id, beat_idx, beat_last,
           fifo_count, bursts_done
  );

  modport master (
    output awid, awaddr, awlen, awvalid, beat_ready,
    input  awready, beat_valid, beat_addr, beat_id, beat_idx, beat_last,
           fifo_count, bursts_done
  );
endinterface

// File: rtl/axi_wr_addr_burst_expander.sv
// Buffers AW commands in a small FIFO and expands each INCR burst into per-beat
// address/ID tokens delivered over a valid/ready handshake.
module axi_wr_addr_burst_expander #(
  parameter int ID_W       = 4,
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 8,
  parameter int DATA_BYTES = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  axi_wr_addr_burst_expander_if.slave  bus
);
  // state   | meaning
  // S_IDLE  | no burst loaded, waiting for a queued command
  // S_BURST | burst loaded, beat token presented to consumer
  localparam int                PTR_W      = $clog2(FIFO_DEPTH);
  localparam int                CNT_W      = PTR_W + 1;
  localparam logic [ADDR_W-1:0] BEAT_STEP  = ADDR_W'(DATA_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(BEAT_STEP - ADDR_W'(1));
  localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [ID_W-1:0]   r_fifo_id   [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [LEN_W-1:0]  r_fifo_len  [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_nxt;
  logic              r_awready;

  logic [ADDR_W-1:0] r_addr;
  logic [ID_W-1:0]   r_id;
  logic [LEN_W-1:0]  r_idx;
  logic [LEN_W-1:0]  r_len;
  logic              r_last;
  logic [15:0]       r_done;

  logic              w_beat_valid;
  logic              w_push;
  logic              w_pop;
  logic              w_accept;
  logic              w_step;
  logic              w_fifo_ne;

  assign w_fifo_ne   = (r_count != '0);
  assign w_push      = bus.awvalid & r_awready;
  assign w_accept    = w_beat_valid & bus.beat_ready;
  // Pop only against pre-edge occupancy, so a same-edge push into an empty FIFO waits a cycle.
  assign w_pop       = w_fifo_ne & ((r_state == S_IDLE) | (w_accept & r_last));
  assign w_step      = w_accept & ~r_last;
  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_fifo_ne) w_state_nxt = S_BURST;
      S_BURST: if (w_accept && r_last && !w_fifo_ne) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_beat_valid = 1'b0;
    if (r_state == S_BURST) w_beat_valid = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_id[r_wptr]   <= bus.awid;
      r_fifo_addr[r_wptr] <= bus.awaddr;
      r_fifo_len[r_wptr]  <= bus.awlen;
    end
  end

  // awready is registered from post-edge occupancy; a pop while full frees space one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_awready <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      r_count   <= w_count_nxt;
      r_awready <= (w_count_nxt < DEPTH_C);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr <= '0;
      r_id   <= '0;
      r_idx  <= '0;
      r_len  <= '0;
      r_last <= 1'b0;
      r_done <= '0;
    end else begin
      if (w_pop) begin
        r_addr <= r_fifo_addr[r_rptr];
        r_id   <= r_fifo_id[r_rptr];
        r_len  <= r_fifo_len[r_rptr];
        r_idx  <= '0;
        r_last <= (r_fifo_len[r_rptr] == '0);
      end else if (w_step) begin
        // Unaligned start addresses snap to the beat grid from the second beat on.
        r_addr <= (r_addr & ALIGN_MASK) + BEAT_STEP;
        r_idx  <= r_idx + LEN_W'(1);
        r_last <= ((r_idx + LEN_W'(1)) == r_len);
      end
      if (w_accept && r_last) r_done <= r_done + 16'd1;
    end
  end

  assign bus.awready     = r_awready;
  assign bus.beat_valid  = w_beat_valid;
  assign bus.beat_addr   = r_addr;
  assign bus.beat_id     = r_id;
  assign bus.beat_idx    = r_idx;
  assign bus.beat_last   = r_last;
  assign bus.fifo_count  = r_count;
  assign bus.bursts_done = r_done;
endmodule

// File: tb/tb_axi_wr_addr_burst_expander.sv
// Self-checking bench: directed scenarios plus randomized AW traffic checked
// against a beat-list reference model.
module tb_axi_wr_addr_burst_expander;
  localparam int ID_W       = 4;
  localparam int ADDR_W     = 32;
  localparam int LEN_W      = 8;
  localparam int DATA_BYTES = 4;
  localparam int FIFO_DEPTH = 4;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  id;
    logic [7:0]  idx;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          exp_done = 0;
  bit          rnd_done = 1'b0;
  beat_t       exp_q[$];
  beat_t       mon_e;
  logic [31:0] seen_addr[$];
  logic [31:0] wrap_exp[6];

  axi_wr_addr_burst_expander_if #(
    .ID_W(ID_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) bus ();

  axi_wr_addr_burst_expander #(
    .ID_W(ID_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W),
    .DATA_BYTES(DATA_BYTES), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: a burst becomes its full list of beats the moment it is accepted.
  task automatic model_push(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    logic [31:0] a;
    beat_t       b;
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      b.addr = a;
      b.id   = id;
      b.idx  = 8'(i);
      b.last = (i == int'(len));
      exp_q.push_back(b);
      a = (a / DATA_BYTES) * DATA_BYTES + DATA_BYTES;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (bus.awvalid && bus.awready) model_push(bus.awid, bus.awaddr, bus.awlen);
      if (bus.beat_valid && bus.beat_ready) begin
        seen_addr.push_back(bus.beat_addr);
        check_val("beat_expected", exp_q.size(), (exp_q.size() == 0) ? 32'd1 : exp_q.size());
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check_val("beat_addr", bus.beat_addr, mon_e.addr);
          check_val("beat_id",   bus.beat_id,   mon_e.id);
          check_val("beat_idx",  bus.beat_idx,  mon_e.idx);
          check_val("beat_last", bus.beat_last, mon_e.last);
          if (mon_e.last) exp_done++;
        end
      end
    end
  end

  task automatic apply_reset();
    rst = 1'b0;
    bus.awvalid    = 1'b0;
    bus.beat_ready = 1'b0;
    exp_q.delete();
    seen_addr.delete();
    exp_done = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Call at posedge+1; returns at posedge+1 just after the handshake edge.
  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    int n;
    n = 0;
    bus.awid    = id;
    bus.awaddr  = addr;
    bus.awlen   = len;
    bus.awvalid = 1'b1;
    while (!bus.awready && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val("aw_timeout", n < 2000, 1);
    @(posedge clk);
    #1;
    bus.awvalid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.beat_valid) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val("drain_timeout", n < budget, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0;
    bus.awvalid = 1'b0; bus.beat_ready = 1'b0;
    wrap_exp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004,
                 32'h0000_1003, 32'h0000_1004};

    // reset state and single burst with latency
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_awready", bus.awready, 0);
    check_val("rst_valid",   bus.beat_valid, 0);
    check_val("rst_count",   bus.fifo_count, 0);
    check_val("rst_done",    bus.bursts_done, 0);
    rst = 1'b1;
    #1;
    check_val("rel_awready_hold", bus.awready, 0);
    @(posedge clk);
    #1;
    check_val("rel_awready", bus.awready, 1);
    bus.beat_ready = 1'b1;
    bus.awid = 4'd5; bus.awaddr = 32'h1000; bus.awlen = 8'd3; bus.awvalid = 1'b1;
    @(posedge clk);
    #1;
    bus.awvalid = 1'b0;
    check_val("lat_valid_t",   bus.beat_valid, 0);
    check_val("lat_count_t",   bus.fifo_count, 1);
    @(posedge clk);
    #1;
    check_val("lat_valid_t1",  bus.beat_valid, 1);
    check_val("lat_addr_t1",   bus.beat_addr, 32'h1000);
    check_val("lat_id_t1",     bus.beat_id, 5);
    check_val("lat_count_t1",  bus.fifo_count, 0);
    drain(100);
    check_val("single_done", bus.bursts_done, 1);

    // backpressure and full FIFO
    apply_reset();
    for (int k = 0; k < 5; k++) send_aw(4'(k + 1), 32'h100 * k, 8'd0);
    check_val("full_count",   bus.fifo_count, 4);
    check_val("full_awready", bus.awready, 0);
    bus.awid = 4'd6; bus.awaddr = 32'h600; bus.awlen = 8'd0; bus.awvalid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("held_awready", bus.awready, 0);
    check_val("held_count",   bus.fifo_count, 4);
    check_val("held_id",      bus.beat_id, 1);
    bus.beat_ready = 1'b1;
    send_aw(4'd6, 32'h600, 8'd0);
    drain(200);
    check_val("full_done",    bus.bursts_done, 6);
    check_val("full_model",   exp_done, 6);

    // back-to-back bursts, no bubble
    apply_reset();
    send_aw(4'd2, 32'h4000, 8'd1);
    send_aw(4'd3, 32'h5000, 8'd1);
    bus.beat_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_val("b2b_valid", bus.beat_valid, 1);
      check_val("b2b_last",  bus.beat_last, i % 2);
      @(posedge clk);
      #1;
    end
    check_val("b2b_idle", bus.beat_valid, 0);
    check_val("b2b_done", bus.bursts_done, 2);

    // address wrap and unaligned start
    apply_reset();
    bus.beat_ready = 1'b1;
    send_aw(4'd1, 32'hFFFF_FFF8, 8'd3);
    send_aw(4'd2, 32'h0000_1003, 8'd1);
    drain(100);
    check_val("wrap_nbeats", seen_addr.size(), 6);
    for (int i = 0; i < 6; i++)
      check_val("wrap_addr", (i < seen_addr.size()) ? seen_addr[i] : 32'hDEAD_BEEF, wrap_exp[i]);

    // stall stability
    apply_reset();
    send_aw(4'd9, 32'h2000, 8'd3);
    @(posedge clk);
    #1;
    bus.beat_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.beat_ready = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      check_val("stall_valid", bus.beat_valid, 1);
      check_val("stall_addr",  bus.beat_addr, 32'h2004);
      check_val("stall_id",    bus.beat_id, 9);
      check_val("stall_idx",   bus.beat_idx, 1);
      check_val("stall_last",  bus.beat_last, 0);
    end
    bus.beat_ready = 1'b1;
    drain(100);
    check_val("stall_done", bus.bursts_done, 1);

    // reset mid-burst with queued commands
    apply_reset();
    bus.beat_ready = 1'b1;
    send_aw(4'd3, 32'h3000, 8'd7);
    send_aw(4'd4, 32'h7000, 8'd1);
    send_aw(4'd5, 32'h8000, 8'd2);
    @(posedge clk);
    #1;
    check_val("pre_rst_idx",   bus.beat_idx, 2);
    check_val("pre_rst_count", bus.fifo_count, 2);
    rst = 1'b0;
    exp_q.delete();
    exp_done = 0;
    #1;
    check_val("mid_rst_awready", bus.awready, 0);
    check_val("mid_rst_valid",   bus.beat_valid, 0);
    check_val("mid_rst_addr",    bus.beat_addr, 0);
    check_val("mid_rst_id",      bus.beat_id, 0);
    check_val("mid_rst_idx",     bus.beat_idx, 0);
    check_val("mid_rst_last",    bus.beat_last, 0);
    check_val("mid_rst_count",   bus.fifo_count, 0);
    check_val("mid_rst_done",    bus.bursts_done, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_val("post_rst_awready", bus.awready, 1);
    check_val("post_rst_count",   bus.fifo_count, 0);
    check_val("post_rst_done",    bus.bursts_done, 0);
    repeat (4) begin
      check_val("post_rst_valid", bus.beat_valid, 0);
      @(posedge clk);
      #1;
    end

    // randomized traffic against the reference model
    apply_reset();
    rnd_done = 1'b0;
    fork
      begin
        for (int b = 0; b < 40; b++) begin
          logic [31:0] a;
          case ($urandom_range(0, 3))
            0:       a = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            1:       a = $urandom & 32'hFFFF_FFFC;
            default: a = $urandom;
          endcase
          send_aw(4'($urandom), a, 8'($urandom_range(0, 9)));
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          bus.beat_ready = ($urandom_range(0, 3) != 0);
          check_val("rnd_occ_bound", bus.fifo_count <= FIFO_DEPTH, 1);
          @(posedge clk);
          #1;
        end
      end
    join
    bus.beat_ready = 1'b1;
    drain(5000);
    check_val("rnd_done",    bus.bursts_done, exp_done);
    check_val("rnd_bursts",  exp_done, 40);
    check_val("rnd_count",   bus.fifo_count, 0);
    check_val("rnd_awready", bus.awready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_wr_addr_burst_expander.md
Name: axi_wr_addr_burst_expander

Overview:
- Downstream consumer of the AXI write-address (AW) channel; acts as the AW slave.
- Accepts AW transactions (awid/awaddr/awlen) into a small FIFO and expands each INCR burst into per-beat address/ID tokens.
- A write-data/memory stage consumes the tokens through a valid/ready handshake.
- Decouples AW acceptance from data-beat rate; awready reflects FIFO space.

Parameters:
- ID_W, 4, width of awid / beat_id
- ADDR_W, 32, width of awaddr / beat_addr
- LEN_W, 8, width of awlen (beats = awlen+1)
- DATA_BYTES, 4, bytes per beat (power of 2); address increment per beat
- FIFO_DEPTH, 4, AW command FIFO entries (power of 2, >=2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- awid  in  ID_W  write transaction ID
- awaddr  in  ADDR_W  burst start byte address
- awlen  in  LEN_W  burst length minus one
- awvalid  in  1  AW valid
- awready  out  1  AW ready; registered, high when FIFO not full
- beat_valid  out  1  beat token valid
- beat_ready  in  1  beat token accepted by consumer
- beat_addr  out  ADDR_W  byte address of current beat
- beat_id  out  ID_W  ID of current burst
- beat_idx  out  LEN_W  beat number within burst, 0..awlen
- beat_last  out  1  high on final beat of burst
- fifo_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- bursts_done  out  16  completed-burst count, wraps at 2^16

Behaviour:
- Reset (rst=0, async): all outputs 0, including awready; FIFO emptied; FSM to IDLE. awready rises at the first clk edge after rst deasserts.
- AW handshake:
  - A transfer occurs at an edge where awvalid & awready; the entry is pushed that edge.
  - awready is registered: next awready = (occupancy after this edge < FIFO_DEPTH).
  - When full, awready is 0 even if a pop occurs the same edge; it recovers the next cycle.
  - awvalid with awready=0 causes no push; the master holds its values.
- FSM IDLE:
  - If FIFO non-empty, pop the head at the edge and load burst registers.
  - beat_addr=awaddr, beat_id=awid, beat_idx=0, beat_last=(awlen==0), beat_valid=1; go to BURST.
  - Latency: AW handshake at edge t → beat_valid=1 after edge t+1.
- FSM BURST:
  - beat_valid=1; beat_addr, beat_id, beat_idx and beat_last are held stable until beat_valid & beat_ready.
  - On a non-last accept: beat_idx+1; beat_addr = (beat_addr & ~(DATA_BYTES-1)) + DATA_BYTES, modulo 2^ADDR_W (unaligned start aligns from beat 1, wraps past all-ones); beat_last=(beat_idx+1==len).
  - On a last accept: bursts_done+1. If the FIFO is non-empty, pop and load the next burst at the same edge (no bubble, beat_valid stays 1). Otherwise beat_valid=0 and go to IDLE.
- Simultaneous push and pop at one edge: fifo_count unchanged; the pushed entry is not popped the same edge when the FIFO was empty (the pop requires pre-edge occupancy).
- fifo_count reflects occupancy after each edge. A loaded burst no longer counts.
- Only INCR bursts are supported, with a fixed DATA_BYTES beat size; no 4KB boundary check.
- Reset mid-burst: burst abandoned, FIFO contents discarded, no partial completion counted.

Test Plan:
- Single burst: awid=5, awaddr=0x1000, awlen=3, beat_ready=1 → beat_valid from the cycle after the handshake; addrs 0x1000,0x1004,0x1008,0x100C; idx 0..3; beat_last only on 4th; bursts_done=1.
- Backpressure/full: beat_ready=0, drive 6 AW txns (awlen=0) → first accepted loads the FSM, next 4 fill the FIFO (fifo_count=4), awready=0, 6th held. Release beat_ready → all 6 beats in order, bursts_done=6.
- Back-to-back: two queued bursts of awlen=1, beat_ready=1 → 4 consecutive beat_valid cycles with no gap; beat_last on beats 2 and 4.
- Address wrap/unaligned: awaddr=0xFFFFFFF8 awlen=3 → 0xFFFFFFF8,0xFFFFFFFC,0x0,0x4. awaddr=0x1003 awlen=1 → 0x1003,0x1004.
- Stall stability: hold beat_ready=0 for 5 cycles mid-burst → beat_addr/id/idx/last unchanged; resumes at the same beat.
- Reset mid-operation: assert rst=0 during beat 2 of awlen=7 with 2 queued → all outputs 0 immediately. After release: awready=1 one edge later, fifo_count=0, bursts_done=0, no stale beats.
